serial_sub: RTL and testbench

//   Bit-serial N-bit subtractor computing {borrow_out, diff} = a - b - bin.

---
 rtl/serial_sub.sv | 112 +++++++++++
 tb/tb_serial_sub.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: {borrow_out, diff} = a - b - bin.
// One full-subtractor cell per clock, LSB first, with a start/busy/done handshake.
module serial_sub #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [N-1:0]  sa, sb, acc, acc_next;
    logic          br;
    logic [CW-1:0] cnt;
    logic          d, bo, last;

    // Full-subtractor cell on the current LSBs; the difference bit enters acc from the top.
    always_comb begin
        d           = sa[0] ^ sb[0] ^ br;
        bo          = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        acc_next    = acc >> 1;
        acc_next[N-1] = d;
        last        = (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are only written on the final SHIFT edge, so they survive a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            br         <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bin;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= bo;
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        diff       <= acc_next;
                        borrow_out <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at N=4, N=1 and N=8.
// Expected results are queued when an operation is launched and popped when done pulses.
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic       start4, bin4, bo4, busy4, done4;
    logic [3:0] a4, b4, diff4;
    logic       start1, bin1, bo1, busy1, done1;
    logic [0:0] a1, b1, diff1;
    logic       start8, bin8, bo8, busy8, done8;
    logic [7:0] a8, b8, diff8;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    serial_sub #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .diff(diff4), .borrow_out(bo4), .busy(busy4), .done(done4)
    );

    serial_sub #(.N(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .diff(diff1), .borrow_out(bo1), .busy(busy1), .done(done1)
    );

    serial_sub #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .diff(diff8), .borrow_out(bo8), .busy(busy8), .done(done8)
    );

    // Reference: bit 8 is the borrow, low n bits the wrapped difference.
    function automatic logic [8:0] exp_val(input int n, input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        return {(r < 0) ? 1'b1 : 1'b0, 8'(r & ((1 << n) - 1))};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [8:0] e;
        int n, busy_cnt;
        @(negedge clk);
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        exp_q.push_back(exp_val(4, a, b, bin));
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        busy_cnt = busy4 ? 1 : 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
            if (busy4) busy_cnt++;
        end
        check({tag, " latency"}, n, 5);
        check({tag, " busy cycles"}, busy_cnt, 5);
        e = exp_q.pop_front();
        check({tag, " diff"}, 32'(diff4), 32'(e[3:0]));
        check({tag, " borrow"}, 32'(bo4), 32'(e[8]));
    endtask

    initial begin
        logic [1:0] tt[8];
        logic [8:0] e;
        int n, busy_cnt, done_cnt;

        tt = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
        rst_n = 1'b0;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset diff", 32'(diff4), 0);
        check("reset borrow", 32'(bo4), 0);
        check("reset busy", 32'(busy4), 0);
        check("reset done", 32'(done4), 0);
        check("reset diff8", 32'(diff8), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic op and wrap-around cases
        run4("t1 9-5", 4'd9, 4'd5, 1'b0);
        @(negedge clk);
        check("t1 done drops", 32'(done4), 0);
        check("t1 busy drops", 32'(busy4), 0);
        check("t1 diff held", 32'(diff4), 4);
        run4("t2 5-9", 4'd5, 4'd9, 1'b0);
        run4("t2 0-15", 4'd0, 4'd15, 1'b0);
        run4("t2 0-0-1", 4'd0, 4'd0, 1'b1);

        // N=1 truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
            exp_q.push_back({7'b0, tt[i]});
            @(negedge clk);
            start1 = 1'b0;
            n = 1;
            while (!done1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("t3 latency %0d", i), n, 2);
            e = exp_q.pop_front();
            check($sformatf("t3 result %0d", i), 32'({bo1, diff1}), 32'(e[1:0]));
        end

        // Start re-pulsed during SHIFT and DONE with new operands
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
        exp_q.push_back(exp_val(4, 3, 1, 0));
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy4) busy_cnt++;
            if (done4) done_cnt++;
            if (k == 1) begin a4 = 4'd15; b4 = 4'd0; end
            if (k == 2) start4 = 1'b0;
            if (k == 5) start4 = 1'b1;
            if (k == 6) start4 = 1'b0;
        end
        check("t4 done pulses", done_cnt, 1);
        check("t4 busy cycles", busy_cnt, 5);
        e = exp_q.pop_front();
        check("t4 diff", 32'(diff4), 32'(e[3:0]));
        check("t4 borrow", 32'(bo4), 32'(e[8]));

        // Asynchronous reset during the second SHIFT cycle
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        @(posedge clk);
        #1;
        check("t5 busy before reset", 32'(busy4), 1);
        check("t5 diff kept on start", 32'(diff4), 2);
        #2 rst_n = 1'b0;
        #1;
        check("t5 async diff", 32'(diff4), 0);
        check("t5 async borrow", 32'(bo4), 0);
        check("t5 async busy", 32'(busy4), 0);
        check("t5 async done", 32'(done4), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run4("t5 7-2", 4'd7, 4'd2, 1'b0);

        // Random N=8 with start held high
        @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        start8 = 1'b1;
        exp_q.push_back(exp_val(8, int'(a8), int'(b8), int'(bin8)));
        for (int op = 0; op < 200; op++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done8 && n < 30);
            check($sformatf("t6 spacing %0d", op), n, (op == 0) ? 9 : 10);
            e = exp_q.pop_front();
            check($sformatf("t6 diff %0d", op), 32'(diff8), 32'(e[7:0]));
            check($sformatf("t6 borrow %0d", op), 32'(bo8), 32'(e[8]));
            if (op == 199) begin
                start8 = 1'b0;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
                exp_q.push_back(exp_val(8, int'(a8), int'(b8), int'(bin8)));
            end
        end
        repeat (3) @(negedge clk);
        check("t6 idle after run", 32'(busy8), 0);
        check("queue drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
